// File: rtl/bin_to_bcd_if.sv
// Handshake/result bundle for the binary-to-BCD converter.
// The master side requests conversions; the slave side (the converter)
// reports progress and drives the registered BCD result.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  i_start;
    logic [WIDTH-1:0]      i_bin;
    logic                  i_lzb;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;

    modport master (
        output i_start,
        output i_bin,
        output i_lzb,
        input  o_busy,
        input  o_done,
        input  o_bcd
    );

    modport slave (
        input  i_start,
        input  i_bin,
        input  i_lzb,
        output o_busy,
        output o_done,
        output o_bcd
    );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// One conversion takes WIDTH shift cycles plus a one-cycle FINISH state
// that pulses DONE. The result register feeds per-digit 7-segment
// decoders, so optional leading-zero blanking (digit code 4'hF) is applied
// when the result is loaded.
module bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    bin_to_bcd_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CAT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // True when DIGITS decimal digits can represent every WIDTH-bit value.
    function automatic bit digits_fit(input int w, input int d);
        logic [127:0] pow10;
        logic [127:0] max_bin;
        pow10 = 128'd1;
        for (int i = 0; i < d; i++) begin
            pow10 = pow10 * 128'd10;
        end
        max_bin = (128'd1 << w) - 128'd1;
        return (pow10 > max_bin);
    endfunction

    generate
        if (!digits_fit(WIDTH, DIGITS)) begin : g_digits_too_few
            $error("bin_to_bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    // Double-dabble correction: every digit >= 5 gets +3, no carry between digits.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = s[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    // Replace leading zero digits (never digit 0) with 4'hF when blanking is on.
    function automatic logic [BCD_W-1:0] lzb_blank(input logic [BCD_W-1:0] s,
                                                   input logic            lzb);
        logic [BCD_W-1:0] r;
        logic             zeros_above;
        logic [3:0]       d;
        r           = s;
        zeros_above = lzb;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            d = s[4*i +: 4];
            if (zeros_above && (d == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = d;
                zeros_above = 1'b0;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_scratch;
    logic [WIDTH-1:0]   r_shift;
    logic               r_lzb;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_busy;
    logic               r_done;

    logic [BCD_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;

    // One double-dabble step on {scratch, shift} and the blanked result it would yield.
    always_comb begin
        w_adj         = dabble_adjust(r_scratch);
        w_cat         = {w_adj, r_shift} << 1'b1;
        w_scratch_nxt = w_cat[CAT_W-1:WIDTH];
        w_shift_nxt   = w_cat[WIDTH-1:0];
        w_bcd_nxt     = lzb_blank(w_scratch_nxt, r_lzb);
    end

    // Control FSM with datapath registers and registered BUSY/DONE/BCD outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_scratch <= '0;
            r_shift   <= '0;
            r_lzb     <= 1'b0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        // Fresh scratch each time so conversions never share state.
                        r_shift   <= bus.i_bin;
                        r_lzb     <= bus.i_lzb;
                        r_scratch <= '0;
                        r_cnt     <= CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_nxt;
                    r_shift   <= w_shift_nxt;
                    r_cnt     <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        // Last step: result is the scratch value this step produces.
                        r_bcd   <= w_bcd_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_bcd  = r_bcd;

endmodule
